// File: rtl/core_lsu_pkg.sv
// Shared definitions for the load/store unit: op kinds, FSM encoding and op decode.
package core_lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NSTRB = XLEN / 8;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_LB,
        OP_LH,
        OP_LW,
        OP_LBU,
        OP_LHU,
        OP_SB,
        OP_SH,
        OP_SW,
        OP_FLW,
        OP_FSW
    } op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Flag order: {FSW, FLW, SW, SH, SB, LHU, LBU, LW, LH, LB}
    function automatic op_e op_from_flags(input logic [9:0] f);
        op_e op;
        op = OP_NONE;
        if (f[0])      op = OP_LB;
        else if (f[1]) op = OP_LH;
        else if (f[2]) op = OP_LW;
        else if (f[3]) op = OP_LBU;
        else if (f[4]) op = OP_LHU;
        else if (f[5]) op = OP_SB;
        else if (f[6]) op = OP_SH;
        else if (f[7]) op = OP_SW;
        else if (f[8]) op = OP_FLW;
        else if (f[9]) op = OP_FSW;
        return op;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane logic: store strobes/data, misalignment check, load extraction.
module core_lsu_align
    import core_lsu_pkg::*;
(
    input  logic [1:0]       addr_lo,
    input  op_e              op,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  frs2,
    input  op_e              ld_op,
    input  logic [1:0]       ld_addr_lo,
    input  logic [XLEN-1:0]  rdata,
    output logic [NSTRB-1:0] wstrb_c,
    output logic [XLEN-1:0]  wdata_c,
    output logic             is_store_c,
    output logic             misalign_c,
    output logic [XLEN-1:0]  load_data_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        wstrb_c    = '0;
        wdata_c    = '0;
        is_store_c = 1'b0;
        misalign_c = 1'b0;
        case (op)
            OP_LH, OP_LHU:  misalign_c = addr_lo[0];
            OP_LW, OP_FLW:  misalign_c = (addr_lo != 2'b00);
            OP_SB: begin
                is_store_c = 1'b1;
                wstrb_c    = 4'b0001 << addr_lo;
                wdata_c    = {4{rs2[7:0]}};
            end
            OP_SH: begin
                is_store_c = 1'b1;
                misalign_c = addr_lo[0];
                wstrb_c    = 4'b0011 << addr_lo;
                wdata_c    = {2{rs2[15:0]}};
            end
            OP_SW, OP_FSW: begin
                is_store_c = 1'b1;
                misalign_c = (addr_lo != 2'b00);
                wstrb_c    = 4'hF;
                wdata_c    = (op == OP_FSW) ? frs2 : rs2;
            end
            default: ;
        endcase
    end

    // Lane selection uses the address latched with the op, not the live bus.
    always_comb begin
        ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (ld_addr_lo)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        load_data_c = '0;
        case (ld_op)
            OP_LB:         load_data_c = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:        load_data_c = {24'h0, ld_byte};
            OP_LH:         load_data_c = {{16{ld_half[15]}}, ld_half};
            OP_LHU:        load_data_c = {16'h0, ld_half};
            OP_LW, OP_FLW: load_data_c = rdata;
            default:       load_data_c = '0;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: one word-aligned request/ack transaction per START, registered outputs.
module core_lsu
    import core_lsu_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             I_LB,
    input  logic             I_LH,
    input  logic             I_LW,
    input  logic             I_LBU,
    input  logic             I_LHU,
    input  logic             I_SB,
    input  logic             I_SH,
    input  logic             I_SW,
    input  logic             I_FLW,
    input  logic             I_FSW,
    input  logic [XLEN-1:0]  ADDR,
    input  logic [XLEN-1:0]  RS2,
    input  logic [XLEN-1:0]  FRS2,
    output logic             MEM_REQ,
    output logic             MEM_WE,
    output logic [XLEN-1:0]  MEM_ADDR,
    output logic [NSTRB-1:0] MEM_WSTRB,
    output logic [XLEN-1:0]  MEM_WDATA,
    input  logic [XLEN-1:0]  MEM_RDATA,
    input  logic             MEM_ACK,
    output logic             BUSY,
    output logic             DONE,
    output logic             MISALIGN,
    output logic [XLEN-1:0]  RDATA,
    output logic             RD_FP
);

    logic [1:0]       state_q, state_d;
    op_e              op_q, op_d, op_in;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
    logic [NSTRB-1:0] mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             misalign_q, misalign_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic             rd_fp_q, rd_fp_d;
    logic             accept;

    logic [NSTRB-1:0] wstrb_c;
    logic [XLEN-1:0]  wdata_c;
    logic             is_store_c;
    logic             misalign_c;
    logic [XLEN-1:0]  load_data_c;

    assign op_in = op_from_flags({I_FSW, I_FLW, I_SW, I_SH, I_SB,
                                  I_LHU, I_LBU, I_LW, I_LH, I_LB});

    core_lsu_align u_align (
        .addr_lo     (ADDR[1:0]),
        .op          (op_in),
        .rs2         (RS2),
        .frs2        (FRS2),
        .ld_op       (op_q),
        .ld_addr_lo  (addr_lo_q),
        .rdata       (MEM_RDATA),
        .wstrb_c     (wstrb_c),
        .wdata_c     (wdata_c),
        .is_store_c  (is_store_c),
        .misalign_c  (misalign_c),
        .load_data_c (load_data_c)
    );

    // A new START is taken in IDLE or in the FIN cycle that is already driving DONE.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_lo_d   = addr_lo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        misalign_d  = misalign_q;
        rdata_d     = rdata_q;
        rd_fp_d     = rd_fp_q;
        accept      = START && ((state_q == ST_IDLE) || ((state_q == ST_FIN) && done_q));

        case (state_q)
            ST_REQ: begin
                if (MEM_ACK) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    rdata_d   = load_data_c;
                    rd_fp_d   = (op_q == OP_FLW);
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                // Suppressed accesses enter FIN without DONE; emit it on the way out.
                if (!done_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (accept) begin
            op_d       = op_in;
            addr_lo_d  = ADDR[1:0];
            busy_d     = 1'b1;
            rdata_d    = '0;
            rd_fp_d    = 1'b0;
            misalign_d = misalign_c;
            if ((op_in == OP_NONE) || misalign_c) begin
                state_d = ST_FIN;
            end else begin
                state_d     = ST_REQ;
                mem_req_d   = 1'b1;
                mem_we_d    = is_store_c;
                mem_addr_d  = {ADDR[XLEN-1:2], 2'b00};
                mem_wstrb_d = wstrb_c;
                mem_wdata_d = wdata_c;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NONE;
            addr_lo_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            rdata_q     <= '0;
            rd_fp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            rdata_q     <= rdata_d;
            rd_fp_q     <= rd_fp_d;
        end
    end

    assign MEM_REQ   = mem_req_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WSTRB = mem_wstrb_q;
    assign MEM_WDATA = mem_wdata_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign MISALIGN  = misalign_q;
    assign RDATA     = rdata_q;
    assign RD_FP     = rd_fp_q;

endmodule
